lz_word_serializer: RTL and testbench
=====================================

Name: lz_word_serializer

Overview:
- Inverse of the leading-zero count path: the block takes a leading-zero count `z` and a payload.
- It builds a len-bit word that has exactly `z` leading zeros, then a marker 1, then the top payload bits.
- It transmits that word serially, MSB-first, with valid/ready handshakes on both sides.
- It sits between count producers (normalisation/priority logic) and serial links or bench checkers that recover `z` by counting leading zeros.

Parameters:
- len, 4, word width in bits; must be >= 2.
- CW (localparam), $clog2(len)+1, width of the count field.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_z  input  CW  requested leading-zero count; legal range 0..len.
- in_payload  input  len  payload; bits [len-1:1] are used, bit 0 is ignored.
- out_valid  output  1  `out_bit` is valid.
- out_ready  input  1  downstream accepts `out_bit`.
- out_bit  output  1  current serial bit, MSB of the word first.
- out_last  output  1  asserted with the final bit (bit 0) of the word.
- word  output  len  parallel copy of the word being or last sent.
- sat  output  1  one-cycle pulse on accept when in_z > len.

Behaviour:
- Reset values: in_ready=0 while rst is high and 1 in the first cycle after release. All other outputs are 0: out_valid, out_bit, out_last, word, sat, state=IDLE, bit counter.
- Word formation on accept:
  - zs = min(in_z, len).
  - word = ({1'b1, in_payload[len-1:1]}) >> zs, logical shift with zero fill.
  - zs==len gives all zeros and no marker.
  - Invariant: the leading-zero count of word equals zs.
- FSM states are IDLE and SEND.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept (in_valid & in_ready): load the shift register and `word`, set cnt=len-1, pulse sat if in_z>len, go to SEND.
- SEND:
  - out_valid=1, out_bit=sreg[len-1], out_last=(cnt==0).
  - On out_valid & out_ready with cnt>0: shift sreg left by one, cnt-1.
  - On the handshake with cnt==0: go to IDLE, unless a new request is accepted in the same cycle.
- Latency: request accepted at edge N, first bit valid after edge N, last bit at the earliest len-1 cycles later.
- Back-to-back: in_ready = IDLE | (SEND & out_ready & cnt==0). A request accepted on the last-bit handshake reloads immediately and stays in SEND, so there are no bubbles.
- Backpressure: while out_ready=0, out_bit, out_last, cnt and sreg all hold.
- in_valid without in_ready: ignored. The producer must hold in_valid and its data until accepted.
- `word` holds its value until the next accept and is not cleared on return to IDLE.
- Reset mid-SEND: the transfer is abandoned with no partial completion. The state, counter, sreg and outputs return to their reset values asynchronously.
- sat is combinationally qualified by the accept and registered, so it pulses for exactly the cycle after the accept edge.

Optional Feature:
- Macro: LZW_SELF_CHECK_EN.
- When defined:
  - Adds output chk_err (1 bit, reset 0).
  - On each accept, the registered `word` is recounted for leading zeros in the following cycle.
  - chk_err pulses for one cycle if the recount differs from the registered zs.
- When undefined: the port and the checking logic are absent, and there is no other behavioural difference.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=1'b0, SEND=1'b1;
  - CW derivation;
  - a `min_sat` function for the count clamp.
- One natural sub-module: lzw_form. It is combinational, takes in_z and in_payload, and returns the formed word and the sat flag. It is reused by the self-check and by the testbench reference model.

Test Plan (len=4):
- z=1, payload=4'b1010 -> word=4'b0110; bits 0,1,1,0 on consecutive cycles with out_ready=1; out_last only on the 4th bit; sat=0.
- z=0, payload=0000, then z=4 back-to-back (in_valid held) -> 1,0,0,0 then 0,0,0,0 with no idle cycle between words; second accept coincides with first out_last handshake.
- z=6 -> word=0000, sat pulses exactly one cycle, 4 zero bits sent.
- z=2, payload=1111, out_ready held low 3 cycles after first bit -> out_bit stays 0, cnt holds, total 4 handshakes produce 0,0,1,1.
- rst asserted after 2 bits of a word -> outputs zero immediately; after release in_ready=1, next request z=3 yields 0,0,0,1 cleanly.
- LZW_SELF_CHECK_EN defined, random z in 0..7 over 1000 words -> chk_err never asserts; recovered leading-zero count of word always equals min(z,4).

Source files
------------

// File: rtl/lz_word_serializer_pkg.sv
// Shared types and helpers for the leading-zero word serializer.
// State encodings, count-field width derivation and the count clamp live here.
package lz_word_serializer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int cw_of(input int l);
        return $clog2(l) + 1;
    endfunction

    function automatic int min_sat(input int z, input int l);
        return (z > l) ? l : z;
    endfunction

endpackage

// File: rtl/lz_word_serializer_form.sv
// Combinational word former: z leading zeros, a marker 1, then payload[len-1:1].
// Also reports the clamped count and whether the request exceeded len.
module lzw_form
    import lz_word_serializer_pkg::*;
#(
    parameter int len = 4,
    localparam int CW = cw_of(len)
) (
    input  logic [CW-1:0]  z,
    input  logic [len-1:0] payload,
    output logic [len-1:0] word,
    output logic [CW-1:0]  zs,
    output logic           sat
);

    logic [len-1:0] marked;
    logic           unused_payload_lsb;

    assign unused_payload_lsb = payload[0];
    assign marked = {1'b1, payload[len-1:1]};
    assign zs     = CW'(min_sat(int'(z), len));
    assign sat    = int'(z) > len;

    // A shift by len pushes the marker out entirely, giving the all-zero word.
    assign word   = marked >> zs;

endmodule

// File: rtl/lz_word_serializer.sv
// Serialises a word with a requested number of leading zeros, MSB first.
// Optional self-check of the formed word is enabled with LZW_SELF_CHECK_EN.
module lz_word_serializer
    import lz_word_serializer_pkg::*;
#(
    parameter int len = 4,
    localparam int CW = cw_of(len)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [CW-1:0]  in_z,
    input  logic [len-1:0] in_payload,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_bit,
    output logic           out_last,
    output logic [len-1:0] word,
`ifdef LZW_SELF_CHECK_EN
    output logic           chk_err,
`endif
    output logic           sat
);

    state_t         state;
    state_t         next_state;
    logic [len-1:0] sreg;
    logic [CW-1:0]  cnt;
    logic [len-1:0] form_word;
    logic [CW-1:0]  form_zs;
    logic           form_sat;
    logic           accept;
    logic           last_hs;

    lzw_form #(.len(len)) u_form (
        .z       (in_z),
        .payload (in_payload),
        .word    (form_word),
        .zs      (form_zs),
        .sat     (form_sat)
    );

    assign last_hs = out_ready && (cnt == '0);
    assign accept  = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A request taken on the last-bit handshake keeps us in SEND with no bubble.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_bit    = 1'b0;
        out_last   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    next_state = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_bit   = sreg[len-1];
                out_last  = (cnt == '0);
                in_ready  = !rst && last_hs;
                if (last_hs && !in_valid) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
            word <= '0;
            sat  <= 1'b0;
        end else begin
            sat <= accept && form_sat;
            if (accept) begin
                sreg <= form_word;
                word <= form_word;
                cnt  <= CW'(len - 1);
            end else if (state == SEND && out_ready && cnt != '0) begin
                sreg <= {sreg[len-2:0], 1'b0};
                cnt  <= cnt - CW'(1);
            end
        end
    end

`ifdef LZW_SELF_CHECK_EN
    logic [CW-1:0] zs_q;
    logic          chk_pend;
    logic [CW-1:0] recount;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zs_q     <= '0;
            chk_pend <= 1'b0;
        end else begin
            chk_pend <= accept;
            if (accept) begin
                zs_q <= form_zs;
            end
        end
    end

    // Ascending scan so the highest set bit is the last one to win.
    always_comb begin
        recount = CW'(len);
        for (int i = 0; i < len; i++) begin
            if (word[i]) begin
                recount = CW'(len - 1 - i);
            end
        end
    end

    assign chk_err = chk_pend && (recount != zs_q);
`else
    logic [CW-1:0] unused_form_zs;
    assign unused_form_zs = form_zs;
`endif

endmodule

// File: tb/tb_lz_word_serializer.sv
// Directed and randomised bench for lz_word_serializer with a bit-level scoreboard.
// Define LZW_SELF_CHECK_EN to also watch chk_err.
module tb_lz_word_serializer;

    localparam int LEN = 4;
    localparam int CW  = $clog2(LEN) + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [CW-1:0]  in_z;
    logic [LEN-1:0] in_payload;
    logic           out_valid;
    logic           out_ready;
    logic           out_bit;
    logic           out_last;
    logic [LEN-1:0] word;
    logic           sat;
`ifdef LZW_SELF_CHECK_EN
    logic           chk_err;
`endif

    int checks   = 0;
    int failures = 0;
    logic bit_q[$];
    logic last_q[$];

    lz_word_serializer #(.len(LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_z       (in_z),
        .in_payload (in_payload),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bit    (out_bit),
        .out_last   (out_last),
        .word       (word),
`ifdef LZW_SELF_CHECK_EN
        .chk_err    (chk_err),
`endif
        .sat        (sat)
    );

    always #5 clk = ~clk;

    function automatic logic [LEN-1:0] exp_word(input int z, input logic [LEN-1:0] p);
        logic [LEN-1:0] w;
        int zs;
        zs = (z > LEN) ? LEN : z;
        for (int i = 0; i < LEN; i++) begin
            if (i < zs)       w[LEN-1-i] = 1'b0;
            else if (i == zs) w[LEN-1-i] = 1'b1;
            else              w[LEN-1-i] = p[LEN-i+zs];
        end
        return w;
    endfunction

    function automatic int lzc(input logic [LEN-1:0] w);
        for (int i = LEN - 1; i >= 0; i--) begin
            if (w[i]) return LEN - 1 - i;
        end
        return LEN;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one request, pushes its expected bits, and returns just after the accept edge.
    task automatic applyStimulus(input int z, input logic [LEN-1:0] p, output logic last_at_accept);
        logic [LEN-1:0] w;
        logic accepted;
        int n;
        w = exp_word(z, p);
        in_valid   = 1'b1;
        in_z       = CW'(z);
        in_payload = p;
        for (int i = LEN - 1; i >= 0; i--) begin
            bit_q.push_back(w[i]);
            last_q.push_back(i == 0);
        end
        accepted = 1'b0;
        last_at_accept = 1'b0;
        n = 0;
        while (!accepted && n < 100) begin
            @(negedge clk);
            accepted = in_ready;
            last_at_accept = out_last;
            n++;
        end
        checkOutput("accept_timeout", {31'b0, accepted}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("word", {28'b0, word}, {28'b0, w});
        checkOutput("sat", {31'b0, sat}, {31'b0, (z > LEN)});
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (bit_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("drain", bit_q.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (bit_q.size() == 0) begin
                checkOutput("unexpected_bit", {31'b0, out_valid}, 32'd0);
            end else begin
                checkOutput("out_bit", {31'b0, out_bit}, {31'b0, bit_q.pop_front()});
                checkOutput("out_last", {31'b0, out_last}, {31'b0, last_q.pop_front()});
            end
        end
`ifdef LZW_SELF_CHECK_EN
        if (!rst) begin
            checkOutput("chk_err", {31'b0, chk_err}, 32'd0);
        end
`endif
    end

    initial begin
        logic la;
        int z;
        logic [LEN-1:0] p;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_z       = '0;
        in_payload = '0;
        out_ready  = 1'b1;

        #2;
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_out_bit", {31'b0, out_bit}, 32'd0);
        checkOutput("rst_out_last", {31'b0, out_last}, 32'd0);
        checkOutput("rst_word", {28'b0, word}, 32'd0);
        checkOutput("rst_sat", {31'b0, sat}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("release_in_ready", {31'b0, in_ready}, 32'd1);

        $display("[TB] basic word z=1");
        applyStimulus(1, 4'b1010, la);
        checkOutput("first_bit_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("first_bit", {31'b0, out_bit}, 32'd0);
        checkOutput("word_0110", {28'b0, word}, 32'h6);
        waitDrain();
        checkOutput("idle_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("idle_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("word_held", {28'b0, word}, 32'h6);

        $display("[TB] back-to-back z=0 then z=4");
        applyStimulus(0, 4'b0000, la);
        checkOutput("word_1000", {28'b0, word}, 32'h8);
        applyStimulus(4, 4'b0000, la);
        checkOutput("b2b_on_last", {31'b0, la}, 32'd1);
        checkOutput("b2b_no_bubble", {31'b0, out_valid}, 32'd1);
        waitDrain();

        $display("[TB] saturating z=6");
        applyStimulus(6, 4'b1111, la);
        @(posedge clk);
        #1;
        checkOutput("sat_one_cycle", {31'b0, sat}, 32'd0);
        waitDrain();

        $display("[TB] backpressure z=2");
        applyStimulus(2, 4'b1111, la);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("bp_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("bp_bit", {31'b0, out_bit}, 32'd0);
            checkOutput("bp_last", {31'b0, out_last}, 32'd0);
        end
        out_ready = 1'b1;
        waitDrain();

        $display("[TB] reset mid-word");
        applyStimulus(0, 4'b1010, la);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        bit_q.delete();
        last_q.delete();
        checkOutput("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("mid_rst_out_bit", {31'b0, out_bit}, 32'd0);
        checkOutput("mid_rst_out_last", {31'b0, out_last}, 32'd0);
        checkOutput("mid_rst_word", {28'b0, word}, 32'd0);
        checkOutput("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        applyStimulus(3, 4'b0000, la);
        checkOutput("word_0001", {28'b0, word}, 32'h1);
        waitDrain();

        $display("[TB] random words");
        for (int k = 0; k < 1000; k++) begin
            z = int'($urandom_range(0, 7));
            p = LEN'($urandom);
            applyStimulus(z, p, la);
            checkOutput("rand_lzc", lzc(word), (z > LEN) ? LEN : z);
        end
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
